adc_frame_capture: RTL and testbench
====================================

# adc_frame_capture

Downstream neighbour of the ISERDES bit-slip aligner. Once the frame clock is aligned, it assembles the two 8-bit deserialised data lanes into 16-bit ADC samples. It also keeps checking the frame pattern for loss of lock. On a threshold trigger it captures a block of samples into on-chip RAM and streams that block out over a valid/ready interface.

## Interface
Parameters:
- DEPTH, 1024, capture length in samples; power of two, 16..4096.
- LOCK_MISS, 4, consecutive bad frame words that declare loss of lock; 1..15.

Ports:
- CLKDIV  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- aligned  in  1  high when the bit-slip aligner has locked.
- ISERDES_FCO  in  8  deserialised frame clock word; F0h when in lock.
- ISERDES_D0  in  8  lane 0 word, carrying the even sample bits.
- ISERDES_D1  in  8  lane 1 word, carrying the odd sample bits.
- arm  in  1  single-cycle pulse that starts a new capture.
- trig_force  in  1  immediate trigger while ARMED.
- trig_level  in  16  rising-edge threshold, unsigned offset-binary.
- sample  out  16  assembled sample, registered.
- sample_valid  out  1  `sample` is from an aligned, in-lock frame.
- m_data  out  16  readout word.
- m_valid  out  1  readout valid.
- m_ready  in  1  readout ready.
- m_last  out  1  marks the final word (index DEPTH-1).
- busy  out  1  state is ARMED or CAPTURE.
- lock_err  out  1  sticky loss-of-lock flag.

## Operation
- Assembly: sample[2k] = D0[k] and sample[2k+1] = D1[k] for k = 0..7. It is registered every cycle.
- sample_valid is asserted when, in the previous cycle, aligned = 1, FCO = F0h, and the miss count was below LOCK_MISS.
- Lock monitor, active only while aligned = 1:
  - The miss counter increments on each FCO ≠ F0h and saturates at LOCK_MISS.
  - It clears on FCO = F0h.
  - Reaching LOCK_MISS forces lock loss.
  - When aligned = 0, the counter is held at 0.
- States: IDLE, ARMED, CAPTURE, DONE, ERROR.
- IDLE:
  - arm=1 and aligned=1 → ARMED.
  - arm=1 and aligned=0 → ERROR, lock_err set.
- ARMED:
  - Trigger fires on either condition: trig_force=1 with sample_valid=1, or prev_sample < trig_level <= sample where both samples are valid and consecutive.
  - The first valid sample after entry only loads prev_sample; it cannot trigger.
  - An invalid sample invalidates prev_sample.
  - On trigger → CAPTURE. The trigger sample is written to address 0.
- CAPTURE:
  - Each sample_valid=1 cycle writes the next address.
  - sample_valid=0 without lock loss pauses writing with no gap marker.
  - After address DEPTH-1 is written → DONE.
- DONE:
  - Streams addresses 0..DEPTH-1 in order on m_data.
  - Once m_last is accepted (m_valid & m_ready) → IDLE.
- ERROR: entered from ARMED or CAPTURE on lock loss or when aligned falls. It stays there until arm.
- lock_err: set on entry to ERROR. Cleared only by arm, which also re-evaluates the IDLE arm rule from ERROR.
- arm is ignored in ARMED and CAPTURE.
- arm in DONE abandons the readout: m_valid drops next cycle and the state goes → ARMED (or → ERROR if aligned=0).
- Write and read addresses are log2(DEPTH) bits wide and do not wrap within a capture.

## Timing
- Reset values:
  - state = IDLE.
  - sample = 0, sample_valid = 0.
  - m_valid = 0, m_last = 0, m_data = 0.
  - busy = 0, lock_err = 0.
  - Miss counter, prev_sample and addresses = 0.
- Input words to sample/sample_valid: 1 cycle.
- Trigger sample present on `sample` in cycle T → CAPTURE visible at T+1, address 0 written at T.
- The Nth valid sample after the trigger goes to address N.
- DONE entry to first m_valid: at most 2 cycles (synchronous RAM read plus output register).
- Readout handshake:
  - m_data, m_last and m_valid stay stable while m_valid & !m_ready.
  - With m_ready held high, throughput is one word per cycle with no bubbles after the first word.
- Lock loss, or aligned falling, at cycle T: ERROR and lock_err at T+1. The partial capture is discarded.
- If arm and lock loss occur in the same DONE cycle, arm wins. Lock loss outside ARMED/CAPTURE does not set lock_err.
- rst_n assertion clears all state immediately, asynchronously, including a readout in progress. Release is synchronous to CLKDIV.

## Test plan
- Bit assembly: D0=FFh, D1=00h, FCO=F0h, aligned=1 → sample=5555h one cycle later with sample_valid=1. D0=00h, D1=FFh → AAAAh.
- Level trigger, DEPTH=16: ramp samples 0,0x100,0x200,..., trig_level=0x0500, arm → capture starts at 0x0500. Readout gives 0x0500..0x1400, m_last on the 16th word, then IDLE.
- Backpressure: toggle m_ready pseudo-randomly during readout → every word appears exactly once in order; m_data is stable while stalled.
- Lock loss, LOCK_MISS=4:
  - In CAPTURE, 3 bad FCO words then F0h → no error.
  - 4 consecutive bad words → ERROR and lock_err=1 one cycle after the 4th.
  - A following arm clears lock_err.
- aligned dropping in ARMED → ERROR. arm while aligned=0 → ERROR. arm in CAPTURE → no effect.
- Async reset mid-readout: assert rst_n=0 between clock edges → m_valid, busy and lock_err are 0 immediately. A new arm captures normally.

Source files
------------

// File: rtl/adc_frame_capture.sv
// Assembles two deserialised 8-bit lanes into 16-bit ADC samples and watches the frame word for loss of lock.
// On a threshold or forced trigger it captures DEPTH samples into RAM and streams them out over valid/ready.
module adc_frame_capture #(
    parameter int DEPTH     = 1024,
    parameter int LOCK_MISS = 4
) (
    input  logic        CLKDIV,
    input  logic        rst_n,
    input  logic        aligned,
    input  logic [7:0]  ISERDES_FCO,
    input  logic [7:0]  ISERDES_D0,
    input  logic [7:0]  ISERDES_D1,
    input  logic        arm,
    input  logic        trig_force,
    input  logic [15:0] trig_level,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        lock_err
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [7:0]  FCO_LOCK = 8'hF0;
    localparam logic [3:0]  MISS_MAX = 4'(LOCK_MISS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DONE, ERROR} state_t;

    state_t          state, state_n;
    logic [15:0]     word;
    logic            fco_ok, lock_loss, trig_hit;
    logic [3:0]      miss_cnt, miss_inc;
    logic [15:0]     prev_sample;
    logic            prev_valid;
    logic [AW-1:0]   waddr, wr_addr, rd_addr;
    logic            wr_en;
    logic [15:0]     mem [DEPTH];
    logic [15:0]     ram_q;
    logic            q_valid, q_last, rd_more;
    logic            rd_run, out_adv, q_adv, rd_fetch;

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            word[2*k]   = ISERDES_D0[k];
            word[2*k+1] = ISERDES_D1[k];
        end
    end

    assign fco_ok    = (ISERDES_FCO == FCO_LOCK);
    assign miss_inc  = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 4'd1;
    // Loss is flagged in the cycle the bad word arrives so ERROR lands one cycle later.
    assign lock_loss = aligned && !fco_ok && (miss_inc == MISS_MAX);
    assign trig_hit  = sample_valid &&
                       (trig_force || (prev_valid && (prev_sample < trig_level) && (trig_level <= sample)));
    assign busy      = (state == ARMED) || (state == CAPTURE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE, ERROR: if (arm) state_n = aligned ? ARMED : ERROR;
            ARMED: begin
                if (!aligned || lock_loss) state_n = ERROR;
                else if (trig_hit)         state_n = CAPTURE;
            end
            CAPTURE: begin
                if (!aligned || lock_loss)                   state_n = ERROR;
                else if (sample_valid && waddr == LAST_ADDR) state_n = DONE;
            end
            DONE: begin
                if (arm)                              state_n = aligned ? ARMED : ERROR;
                else if (m_valid && m_ready && m_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = ((state == ARMED) && trig_hit) || ((state == CAPTURE) && sample_valid);
        wr_addr = (state == ARMED) ? '0 : waddr;
    end

    always_ff @(posedge CLKDIV or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lock_err     <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            miss_cnt     <= '0;
            prev_sample  <= '0;
            prev_valid   <= 1'b0;
            waddr        <= '0;
        end else begin
            state        <= state_n;
            lock_err     <= (state_n == ERROR);
            sample       <= word;
            sample_valid <= aligned && fco_ok && (miss_cnt < MISS_MAX);
            miss_cnt     <= (!aligned || fco_ok) ? '0 : miss_inc;
            if (state == ARMED && sample_valid) begin
                prev_sample <= sample;
                prev_valid  <= 1'b1;
            end else begin
                prev_valid  <= 1'b0;
            end
            if (state == ARMED)
                waddr <= AW'(1);
            else if (state == CAPTURE && sample_valid)
                waddr <= waddr + AW'(1);
        end
    end

    // Two-stage readout (RAM register, output register); each stage refills whenever the one ahead moves.
    assign rd_run   = (state == DONE) && (state_n == DONE);
    assign out_adv  = !m_valid || m_ready;
    assign q_adv    = !q_valid || out_adv;
    assign rd_fetch = rd_run && q_adv && rd_more;

    always_ff @(posedge CLKDIV) begin
        if (wr_en)    mem[wr_addr] <= sample;
        if (rd_fetch) ram_q        <= mem[rd_addr];
    end

    always_ff @(posedge CLKDIV or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
            rd_addr <= '0;
            rd_more <= 1'b0;
        end else if (!rd_run) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
            rd_addr <= '0;
            rd_more <= 1'b1;
        end else begin
            if (rd_fetch) begin
                q_valid <= 1'b1;
                q_last  <= (rd_addr == LAST_ADDR);
                rd_addr <= rd_addr + AW'(1);
                if (rd_addr == LAST_ADDR) rd_more <= 1'b0;
            end else if (q_adv) begin
                q_valid <= 1'b0;
            end
            if (out_adv) begin
                m_valid <= q_valid;
                m_data  <= ram_q;
                m_last  <= q_valid && q_last;
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_capture.sv
// Scoreboard bench for adc_frame_capture: captured words are queued as driven and compared as they are read out.
module tb_adc_frame_capture;
    localparam int DEPTH     = 16;
    localparam int LOCK_MISS = 4;

    logic        CLKDIV = 1'b0;
    logic        rst_n;
    logic        aligned;
    logic [7:0]  ISERDES_FCO, ISERDES_D0, ISERDES_D1;
    logic        arm, trig_force;
    logic [15:0] trig_level;
    logic [15:0] sample, m_data;
    logic        sample_valid, m_valid, m_ready, m_last, busy, lock_err;

    adc_frame_capture #(.DEPTH(DEPTH), .LOCK_MISS(LOCK_MISS)) dut (
        .CLKDIV(CLKDIV), .rst_n(rst_n), .aligned(aligned),
        .ISERDES_FCO(ISERDES_FCO), .ISERDES_D0(ISERDES_D0), .ISERDES_D1(ISERDES_D1),
        .arm(arm), .trig_force(trig_force), .trig_level(trig_level),
        .sample(sample), .sample_valid(sample_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .lock_err(lock_err)
    );

    always #5 CLKDIV = ~CLKDIV;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge CLKDIV);
        #1;
    endtask

    task automatic drive(input logic [15:0] w, input bit good);
        for (int k = 0; k < 8; k++) begin
            ISERDES_D0[k] = w[2*k];
            ISERDES_D1[k] = w[2*k+1];
        end
        ISERDES_FCO = good ? 8'hF0 : 8'h0F;
    endtask

    // Readout monitor: pops on each accepted word and checks holding while stalled.
    logic        stall_prev = 1'b0;
    logic [15:0] held;
    always @(negedge CLKDIV) begin
        logic [15:0] e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_valid & m_ready, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", m_data, e);
                    check("rd_last", m_last, exp_q.size() == 0);
                end
            end
            stall_prev = m_valid && !m_ready;
            held       = m_data;
        end
    end

    task automatic run_capture(input int n, input int arm_at, input int bad_at, input bit push);
        int pushed = 0;
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            drive(w, i != bad_at);
            arm = (i == 0) || (i == arm_at);
            if (push && i != bad_at && pushed < DEPTH) begin
                exp_q.push_back(w);
                pushed++;
            end
            tick;
            if (i == arm_at) check("arm_in_capture_busy", busy, 1);
        end
        arm = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 400) begin
            m_ready = rnd ? 1'($urandom) : 1'b1;
            tick;
            n++;
        end
        m_ready = 1'b1;
        check("drain_left", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_mvalid", m_valid, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; aligned = 1'b0; arm = 1'b0; trig_force = 1'b0;
        trig_level = '0; m_ready = 1'b1;
        ISERDES_FCO = '0; ISERDES_D0 = '0; ISERDES_D1 = '0;
        tick; tick;
        check("rst_sample", sample, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_lock_err", lock_err, 0);
        rst_n = 1'b1;
        tick;

        // Bit assembly
        aligned = 1'b1;
        ISERDES_FCO = 8'hF0; ISERDES_D0 = 8'hFF; ISERDES_D1 = 8'h00;
        tick;
        check("asm_5555", sample, 16'h5555);
        check("asm_valid", sample_valid, 1);
        ISERDES_D0 = 8'h00; ISERDES_D1 = 8'hFF;
        tick;
        check("asm_AAAA", sample, 16'hAAAA);
        ISERDES_FCO = 8'h0F;
        tick;
        check("asm_badfco_invalid", sample_valid, 0);

        // Level trigger on a ramp
        trig_force = 1'b0; trig_level = 16'h0500;
        for (int i = 0; i < 25; i++) begin
            drive(16'(i * 256), 1'b1);
            arm = (i == 0);
            if (i * 256 >= 16'h0500 && i * 256 <= 16'h1400) exp_q.push_back(16'(i * 256));
            tick;
            if (i == 0) check("armed_busy", busy, 1);
        end
        arm = 1'b0;
        drain(1'b0);

        // Forced trigger, one bad frame pause, ignored arm, random backpressure
        trig_force = 1'b1; m_ready = 1'b0;
        run_capture(24, 5, 8, 1'b1);
        drain(1'b1);

        // Lock monitor
        drive(16'h1234, 1'b1); arm = 1'b1; tick; arm = 1'b0;
        drive(16'h1111, 1'b1); tick;
        drive(16'h2222, 1'b1); tick;
        for (int k = 0; k < 3; k++) begin drive(16'h0, 1'b0); tick; end
        drive(16'h3333, 1'b1); tick;
        check("miss3_busy", busy, 1);
        check("miss3_lock_err", lock_err, 0);
        for (int k = 0; k < 4; k++) begin
            drive(16'h0, 1'b0); tick;
            if (k == 2) begin
                check("bad3_busy", busy, 1);
                check("bad3_lock_err", lock_err, 0);
            end
        end
        check("bad4_lock_err", lock_err, 1);
        check("bad4_busy", busy, 0);
        trig_force = 1'b0; trig_level = 16'hFFFF;
        drive(16'h0, 1'b1); arm = 1'b1; tick; arm = 1'b0;
        check("rearm_lock_err", lock_err, 0);
        check("rearm_busy", busy, 1);
        tick; tick;
        aligned = 1'b0; tick;
        check("aligned_drop_lock_err", lock_err, 1);
        check("aligned_drop_busy", busy, 0);

        // Async reset during a stalled readout
        aligned = 1'b1; trig_force = 1'b1; m_ready = 1'b0;
        run_capture(24, -1, -1, 1'b0);
        n = 0;
        while (!m_valid && n < 60) begin tick; n++; end
        check("pre_reset_m_valid", m_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_lock_err", lock_err, 0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // arm while unaligned, then a clean capture
        aligned = 1'b0; drive(16'h0, 1'b1); arm = 1'b1; tick; arm = 1'b0;
        check("arm_unaligned_lock_err", lock_err, 1);
        check("arm_unaligned_busy", busy, 0);
        aligned = 1'b1; m_ready = 1'b1;
        run_capture(20, -1, -1, 1'b1);
        drain(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
